// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit and its scoreboard.
package hazard_pkg;

  // EXE operand source selects
  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;

  // Register address fields in the scoreboard are sized for the widest core
  // this unit is expected to serve; narrower REG_AW values are zero-extended.
  localparam int SB_AW = 8;

  typedef struct packed {
    logic             v;
    logic [SB_AW-1:0] dest;
    logic             wb;
    logic             ld;
    logic             s;
    logic [SB_AW-1:0] src1;
    logic [SB_AW-1:0] src2;
    logic             two;
  } sb_entry_t;

  // Entry holds a live instruction that will write register r.
  function automatic logic sb_match(input sb_entry_t e, input logic [SB_AW-1:0] r);
    return e.v & e.wb & (e.dest == r);
  endfunction

endpackage

// File: rtl/sb_entry_reg.sv
// One scoreboard entry register: synchronous clear, hold, or load.
module sb_entry_reg
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  sb_entry_t d,
  output sb_entry_t q
);

  // Clear on reset, otherwise load unless the pipeline is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard detector and EXE forwarding control driven by a private
// three-entry scoreboard (EXE, MEM, WB) of in-flight instructions.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter bit FWD_EN       = 1'b1,
  parameter bit SR_HAZARD_EN = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze_in,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              id_s,
  input  logic              id_cond_live,
  output logic              hazard,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt
);

  sb_entry_t sb_d [3];
  sb_entry_t sb_q [3];

  logic [SB_AW-1:0] src1_x;
  logic [SB_AW-1:0] src2_x;

  assign src1_x = SB_AW'(id_src1);
  assign src2_x = SB_AW'(id_src2);

  // Entry 0 takes the ID instruction, killed by a stall or flush; older entries shift.
  always_comb begin
    sb_d[0]      = '0;
    sb_d[0].v    = id_valid & ~hazard & ~flush;
    sb_d[0].dest = SB_AW'(id_dest);
    sb_d[0].wb   = id_wb_en;
    sb_d[0].ld   = id_mem_r_en;
    sb_d[0].s    = id_s;
    sb_d[0].src1 = src1_x;
    sb_d[0].src2 = src2_x;
    sb_d[0].two  = id_two_src;
    sb_d[1]      = sb_q[0];
    sb_d[2]      = sb_q[1];
  end

  for (genvar k = 0; k < 3; k++) begin : g_sb
    sb_entry_reg u_entry (
      .clk  (clk),
      .rst  (rst),
      .hold (freeze_in),
      .d    (sb_d[k]),
      .q    (sb_q[k])
    );
  end

  logic raw_exe;
  logic raw_mem;
  logic haz_data;
  logic haz_flag;

  // ID stall: data/load-use hazard against EXE/MEM plus the status-flag hazard.
  always_comb begin
    raw_exe  = sb_match(sb_q[0], src1_x) | (id_two_src & sb_match(sb_q[0], src2_x));
    raw_mem  = sb_match(sb_q[1], src1_x) | (id_two_src & sb_match(sb_q[1], src2_x));
    haz_data = 1'b0;
    haz_flag = 1'b0;
    if (FWD_EN) begin
      haz_data = raw_exe & sb_q[0].ld;
    end else begin
      // WB needs no stall: the register file writes before ID reads.
      haz_data = raw_exe | raw_mem;
    end
    if (SR_HAZARD_EN) begin
      haz_flag = id_cond_live & sb_q[0].v & sb_q[0].s;
    end
    hazard = id_valid & (haz_data | haz_flag);
  end

  // EXE operand selects for the instruction in entry 0; MEM wins over WB.
  always_comb begin
    fwd_sel1 = FWD_NONE;
    fwd_sel2 = FWD_NONE;
    if (FWD_EN && sb_q[0].v) begin
      if (sb_match(sb_q[1], sb_q[0].src1)) begin
        fwd_sel1 = FWD_MEM;
      end else if (sb_match(sb_q[2], sb_q[0].src1)) begin
        fwd_sel1 = FWD_WB;
      end
      if (sb_q[0].two) begin
        if (sb_match(sb_q[1], sb_q[0].src2)) begin
          fwd_sel2 = FWD_MEM;
        end else if (sb_match(sb_q[2], sb_q[0].src2)) begin
          fwd_sel2 = FWD_WB;
        end
      end
    end
  end

  // Saturating count of stalled cycles; frozen cycles are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!freeze_in) begin
      if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised successor to the pipeline hazard detector for the five-stage ARM core. It keeps its own three-entry scoreboard of in-flight instructions (EXE, MEM, WB) instead of reading stage-register destinations. From that scoreboard it generates:
- an ID stall for data, load-use and status-flag hazards;
- EXE forwarding selects, when forwarding is enabled;
- a saturating stall counter.

It sits beside the ID stage. The `hazard` output feeds ID (bubble insertion) and the IF/ID register freeze.

## Interface
Parameters:
- `REG_AW`, 4, register-address width (16 architectural registers).
- `FWD_EN`, 1, 1 = forward from MEM/WB with load-use stall only; 0 = stall on any RAW against EXE or MEM.
- `SR_HAZARD_EN`, 1, 1 = stall a conditional ID instruction while a flag-setting instruction is in EXE.
- `CNT_W`, 16, stall counter width.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `freeze_in`  in  1  external pipeline hold (memory wait); scoreboard holds.
- `flush`  in  1  branch taken in EXE; the ID instruction is killed.
- `id_valid`  in  1  ID holds a real instruction.
- `id_src1`, `id_src2`  in  REG_AW  ID source registers.
- `id_two_src`  in  1  `id_src2` is live.
- `id_dest`  in  REG_AW  ID destination register.
- `id_wb_en`, `id_mem_r_en`, `id_s`  in  1  ID write-back, load and set-flags controls.
- `id_cond_live`  in  1  ID condition field is not AL.
- `hazard`  out  1  stall ID/IF this cycle.
- `fwd_sel1`, `fwd_sel2`  out  2  EXE operand select: 0 = register value, 1 = MEM ALU result, 2 = WB value.
- `stall_cnt`  out  CNT_W  cycles with `hazard`=1, saturating.

## Operation
- Scoreboard entry k (0 = EXE, 1 = MEM, 2 = WB) holds: `v`, `dest`, `wb`, `ld`, `s`, `src1`, `src2`, `two`.
- Match(k, r) = `v[k]` & `wb[k]` & (`dest[k]` == r).
- RAW(k) = Match(k, `id_src1`) | (`id_two_src` & Match(k, `id_src2`)).
- `hazard` is combinational and gated by `id_valid`. It is the OR of:
  - FWD_EN=0: RAW(0) | RAW(1). WB is covered by register-file write-before-read.
  - FWD_EN=1: RAW(0) & `ld[0]` (load-use).
  - SR_HAZARD_EN=1: `id_cond_live` & `v[0]` & `s[0]`.
- Forwarding (FWD_EN=1) is combinational, evaluated for entry 0:
  - `fwd_sel1` = 1 if Match(1, `src1[0]`), else 2 if Match(2, `src1[0]`), else 0.
  - `fwd_sel2` follows the same rule using `src2[0]`, qualified by `two[0]`.
  - MEM has priority over WB.
  - Forced 0 when `v[0]`=0 or FWD_EN=0.
- Scoreboard update on each rising `clk`:
  - `rst`: all `v` and `stall_cnt` cleared.
  - else if `freeze_in`: all entries hold; `stall_cnt` holds.
  - else:
    - Entries shift (2←1, 1←0).
    - Entry 0 loads the ID fields with `v` = `id_valid` & ~`hazard` & ~`flush`. Otherwise it loads a bubble (`v`=0).
    - `stall_cnt` increments if `hazard`, saturating at all-ones.
- `flush` and `hazard` together: a bubble is inserted and `stall_cnt` still increments.
- A dest match with `wb`=0 (store, compare) is never a hazard.

## Timing
- Reset values: `hazard`=0, `fwd_sel1`=`fwd_sel2`=0, `stall_cnt`=0. All `v`=0, so no hazard is possible after reset.
- `hazard` and `fwd_sel*` have zero latency: combinational from ID inputs and registered scoreboard state.
- Load-use, FWD_EN=1:
  - exactly 1 stall cycle;
  - the dependent instruction then sees `fwd_sel`=2 in EXE.
- RAW, FWD_EN=0:
  - producer in EXE gives 2 stall cycles;
  - producer in MEM gives 1.
- Flag hazard: 1 stall cycle.
- `freeze_in`: stall cycles extend by the freeze length; the stall condition is re-evaluated each cycle.
- Reset mid-stall: the next cycle has `hazard`=0 and the scoreboard is empty.

## Structure
- Shared package `hazard_pkg` holds:
  - the `FWD_NONE`/`FWD_MEM`/`FWD_WB` constants;
  - the scoreboard entry struct.
- One sub-module, `sb_entry_reg`: one scoreboard entry register with hold/load/clear, instantiated three times.
- Hazard and forward logic stays in the top module.

## Test plan
- Reset, then `id_valid`=1, `src1`=R3 with an empty scoreboard → `hazard`=0, `fwd_sel1`=0, `stall_cnt`=0.
- FWD_EN=1: ADD R1 issues, then SUB R2,R1,R4 → no stall; next cycle in EXE, `fwd_sel1`=1.
- FWD_EN=1: LDR R5 issues, then ADD R6,R5,R5 → `hazard`=1 for exactly 1 cycle; then `fwd_sel1`=`fwd_sel2`=2; `stall_cnt`=1.
- FWD_EN=0: ADD R1 issues, then ORR R2,R1 → `hazard`=1 for 2 cycles; `fwd_sel`=0 throughout.
- CMP (`s`=1) issues, then BEQ (`id_cond_live`=1) → 1 stall. Same sequence with SR_HAZARD_EN=0 → no stall.
- Load-use stall with `freeze_in`=1 for 3 cycles → `hazard` held 4 cycles and the scoreboard is unchanged. Separately, `flush` with a dependent ID instruction → entry 0 is a bubble and no later forward is seen.
